// File: rtl/cpu_bus_arbiter_pkg.sv
// Shared constants for the CPU bus arbiter: FSM state encodings and default error data.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package cpu_bus_arbiter_pkg;

  typedef enum logic [1:0] {
    ARB_IDLE = 2'd0,
    ARB_BUSY = 2'd1,
    ARB_DONE = 2'd2
  } arb_state_t;

  localparam logic [31:0] DEF_ERR_DATA = 32'h0;

  // Width of a channel index; never below one bit so a single-master build still elaborates.
  function automatic int ptr_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/cpu_bus_arbiter_rr.sv
// Request arbiter: round-robin from (last grant + 1) or fixed priority (highest index wins).
// Latency: grant is combinational; pointer updates on the clock edge that accepts a grant.
// Backpressure: none; i_upd qualifies when the current grant is actually taken.
module cpu_bus_arbiter_rr #(
  parameter int N       = 2,
  parameter int PW      = 1,
  parameter bit RR_MODE = 1'b1
) (
  input  logic          i_clk,
  input  logic          i_rst,
  input  logic [N-1:0]  i_req,
  input  logic          i_upd,
  output logic [N-1:0]  o_gnt,
  output logic [PW-1:0] o_idx
);

  logic [PW-1:0] r_ptr;
  logic [PW-1:0] w_idx;
  logic [PW-1:0] w_cand;
  logic          w_found;

  // Pick the winning channel index from the request vector.
  always_comb begin
    w_idx   = '0;
    w_cand  = '0;
    w_found = 1'b0;
    if (RR_MODE) begin
      for (int i = 0; i < N; i++) begin
        w_cand = PW'((int'(r_ptr) + 1 + i) % N);
        if (!w_found && i_req[w_cand]) begin
          w_found = 1'b1;
          w_idx   = w_cand;
        end
      end
    end else begin
      for (int i = 0; i < N; i++) begin
        if (i_req[PW'(i)]) begin
          w_idx = PW'(i);
        end
      end
    end
  end

  // Remember the last granted channel so the search starts just after it.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_ptr <= '0;
    end else if (i_upd) begin
      r_ptr <= w_idx;
    end
  end

  assign o_idx = w_idx;
  assign o_gnt = (|i_req) ? (N'(1) << w_idx) : '0;

endmodule

// File: rtl/cpu_bus_arbiter.sv
// Bus interface unit: arbitrates N masters onto one req/ack memory port, with bus-error timeout.
// Latency: ack two cycles after the request is sampled with a zero-wait memory, +1 per wait state.
// Backpressure: masters hold iReq until their oAck; memory stalls by withholding iMemAck.
module cpu_bus_arbiter
  import cpu_bus_arbiter_pkg::*;
#(
  parameter int                NUM_MASTERS = 2,
  parameter int                ADDR_W      = 32,
  parameter int                DATA_W      = 32,
  parameter bit                RR_MODE     = 1'b1,
  parameter int                TIMEOUT     = 255,
  parameter logic [DATA_W-1:0] ERR_DATA    = DATA_W'(DEF_ERR_DATA)
) (
  input  logic                                iCLK,
  input  logic                                iRST,
  input  logic [NUM_MASTERS-1:0]              iReq,
  input  logic [NUM_MASTERS-1:0]              iWe,
  input  logic [NUM_MASTERS*(DATA_W/8)-1:0]   iBe,
  input  logic [NUM_MASTERS*ADDR_W-1:0]       iAddr,
  input  logic [NUM_MASTERS*DATA_W-1:0]       iWData,
  output logic [NUM_MASTERS-1:0]              oAck,
  output logic                                oErr,
  output logic [DATA_W-1:0]                   oRData,
  output logic                                oMemReq,
  output logic                                oMemWe,
  output logic [DATA_W/8-1:0]                 oMemBe,
  output logic [ADDR_W-1:0]                   oMemAddr,
  output logic [DATA_W-1:0]                   oMemWData,
  input  logic                                iMemAck,
  input  logic [DATA_W-1:0]                   iMemRData,
  output logic [NUM_MASTERS-1:0]              oGrant,
  output logic [31:0]                         oStallCnt
);

  localparam int BE_W = DATA_W / 8;
  localparam int PW   = ptr_w(NUM_MASTERS);

  arb_state_t             r_state;
  arb_state_t             w_state_nxt;
  logic                   w_take;
  logic                   w_tmo;
  logic [NUM_MASTERS-1:0] w_arb_gnt;
  logic [PW-1:0]          w_arb_idx;
  logic                   w_sel_we;
  logic [BE_W-1:0]        w_sel_be;

  logic [NUM_MASTERS-1:0] r_grant;
  logic                   r_we;
  logic [BE_W-1:0]        r_be;
  logic [ADDR_W-1:0]      r_addr;
  logic [DATA_W-1:0]      r_wdata;
  logic [DATA_W-1:0]      r_rdata;
  logic                   r_err;
  logic [31:0]            r_tcnt;
  logic [31:0]            r_stall;

  cpu_bus_arbiter_rr #(
    .N       (NUM_MASTERS),
    .PW      (PW),
    .RR_MODE (RR_MODE)
  ) u_rr (
    .i_clk (iCLK),
    .i_rst (iRST),
    .i_req (iReq),
    .i_upd (w_take),
    .o_gnt (w_arb_gnt),
    .o_idx (w_arb_idx)
  );

  assign w_sel_we = iWe[w_arb_idx];
  assign w_sel_be = iBe[int'(w_arb_idx)*BE_W +: BE_W];

  // State register; reset aborts any transaction in flight.
  always_ff @(posedge iCLK or posedge iRST) begin
    if (iRST) begin
      r_state <= ARB_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next state plus the grant-accept and timeout strobes.
  always_comb begin
    w_state_nxt = r_state;
    w_take      = 1'b0;
    w_tmo       = 1'b0;
    case (r_state)
      ARB_IDLE: begin
        if (|iReq) begin
          w_take = 1'b1;
          // A write with no byte lanes touches nothing, so skip the memory cycle.
          w_state_nxt = (w_sel_we && (w_sel_be == '0)) ? ARB_DONE : ARB_BUSY;
        end
      end
      ARB_BUSY: begin
        if (iMemAck) begin
          w_state_nxt = ARB_DONE;
        end else if ((TIMEOUT != 0) && (r_tcnt == 32'(TIMEOUT - 1))) begin
          w_tmo       = 1'b1;
          w_state_nxt = ARB_DONE;
        end
      end
      ARB_DONE: w_state_nxt = ARB_IDLE;
      default:  w_state_nxt = ARB_IDLE;
    endcase
  end

  // Latch the winning transaction, capture read data and the completion status.
  always_ff @(posedge iCLK or posedge iRST) begin
    if (iRST) begin
      r_grant <= '0;
      r_we    <= 1'b0;
      r_be    <= '0;
      r_addr  <= '0;
      r_wdata <= '0;
      r_rdata <= '0;
      r_err   <= 1'b0;
    end else begin
      if (w_take) begin
        r_grant <= w_arb_gnt;
        r_we    <= w_sel_we;
        r_be    <= w_sel_be;
        r_addr  <= iAddr[int'(w_arb_idx)*ADDR_W +: ADDR_W];
        r_wdata <= iWData[int'(w_arb_idx)*DATA_W +: DATA_W];
        r_err   <= 1'b0;
      end else if (r_state == ARB_DONE) begin
        r_grant <= '0;
      end
      if ((r_state == ARB_BUSY) && iMemAck && !r_we) begin
        r_rdata <= iMemRData;
      end else if (w_tmo) begin
        r_rdata <= ERR_DATA;
        r_err   <= 1'b1;
      end
    end
  end

  // Wait-cycle counter for the bus-error timeout; restarts with every new transaction.
  always_ff @(posedge iCLK or posedge iRST) begin
    if (iRST) begin
      r_tcnt <= '0;
    end else if (w_take) begin
      r_tcnt <= '0;
    end else if ((r_state == ARB_BUSY) && (r_tcnt != '1)) begin
      r_tcnt <= r_tcnt + 32'd1;
    end
  end

  // Saturating count of cycles in which some master is left waiting.
  always_ff @(posedge iCLK or posedge iRST) begin
    if (iRST) begin
      r_stall <= '0;
    end else if ((|(iReq & ~oAck)) && (r_stall != '1)) begin
      r_stall <= r_stall + 32'd1;
    end
  end

  assign oAck      = (r_state == ARB_DONE) ? r_grant : '0;
  assign oErr      = (r_state == ARB_DONE) && r_err;
  assign oRData    = r_rdata;
  assign oMemReq   = (r_state == ARB_BUSY);
  assign oMemWe    = r_we;
  assign oMemBe    = r_be;
  assign oMemAddr  = r_addr;
  assign oMemWData = r_wdata;
  assign oGrant    = r_grant;
  assign oStallCnt = r_stall;

endmodule

// File: tb/tb_cpu_bus_arbiter.sv
module tb_cpu_bus_arbiter;

  logic        iCLK = 1'b0;
  logic        iRST;
  logic [1:0]  iReq, iWe;
  logic [7:0]  iBe;
  logic [63:0] iAddr, iWData;
  logic        iMemAck;
  logic [31:0] iMemRData;

  logic [1:0]  oAck, oGrant;
  logic        oErr, oMemReq, oMemWe;
  logic [31:0] oRData, oMemAddr, oMemWData, oStallCnt;
  logic [3:0]  oMemBe;

  logic [1:0]  fp_oAck, fp_oGrant;
  logic        fp_oErr, fp_oMemReq, fp_oMemWe;
  logic [31:0] fp_oRData, fp_oMemAddr, fp_oMemWData, fp_oStallCnt;
  logic [3:0]  fp_oMemBe;

  always #5 iCLK = ~iCLK;

  cpu_bus_arbiter #(
    .NUM_MASTERS(2), .ADDR_W(32), .DATA_W(32), .RR_MODE(1'b1),
    .TIMEOUT(4), .ERR_DATA(32'hDEADBEEF)
  ) dut (
    .iCLK(iCLK), .iRST(iRST), .iReq(iReq), .iWe(iWe), .iBe(iBe), .iAddr(iAddr),
    .iWData(iWData), .oAck(oAck), .oErr(oErr), .oRData(oRData), .oMemReq(oMemReq),
    .oMemWe(oMemWe), .oMemBe(oMemBe), .oMemAddr(oMemAddr), .oMemWData(oMemWData),
    .iMemAck(iMemAck), .iMemRData(iMemRData), .oGrant(oGrant), .oStallCnt(oStallCnt)
  );

  cpu_bus_arbiter #(
    .NUM_MASTERS(2), .ADDR_W(32), .DATA_W(32), .RR_MODE(1'b0),
    .TIMEOUT(0), .ERR_DATA(32'hDEADBEEF)
  ) dut_fp (
    .iCLK(iCLK), .iRST(iRST), .iReq(iReq), .iWe(iWe), .iBe(iBe), .iAddr(iAddr),
    .iWData(iWData), .oAck(fp_oAck), .oErr(fp_oErr), .oRData(fp_oRData),
    .oMemReq(fp_oMemReq), .oMemWe(fp_oMemWe), .oMemBe(fp_oMemBe), .oMemAddr(fp_oMemAddr),
    .oMemWData(fp_oMemWData), .iMemAck(iMemAck), .iMemRData(iMemRData),
    .oGrant(fp_oGrant), .oStallCnt(fp_oStallCnt)
  );

  typedef struct {
    logic [1:0]  ack;
    logic        err;
    logic [31:0] rdata;
    logic        we;
    logic [31:0] addr;
    logic [3:0]  be;
    logic [31:0] wdata;
    int          busy;
    int          lat;
  } exp_t;

  exp_t sb[$];
  int   n_vec = 0;
  int   n_err = 0;

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic set_ch(input int ch, input logic we, input logic [3:0] be,
                        input logic [31:0] addr, input logic [31:0] wdata);
    iWe[ch]            = we;
    iBe[ch*4 +: 4]     = be;
    iAddr[ch*32 +: 32] = addr;
    iWData[ch*32 +: 32] = wdata;
  endtask

  task automatic push(input logic [1:0] ack, input logic err, input logic [31:0] rdata,
                      input logic we, input logic [31:0] addr, input logic [3:0] be,
                      input logic [31:0] wdata, input int busy, input int lat);
    exp_t e;
    e.ack = ack; e.err = err; e.rdata = rdata; e.we = we; e.addr = addr;
    e.be = be; e.wdata = wdata; e.busy = busy; e.lat = lat;
    sb.push_back(e);
  endtask

  // Memory responder + scoreboard pop. ws < 0 means the memory never answers.
  task automatic wait_ack(input int ws, input logic [31:0] mrd, input bit drop);
    exp_t e;
    int   n_busy;
    bit   got;
    n_busy = 0;
    got    = 1'b0;
    for (int c = 0; c < 40 && !got; c++) begin
      @(negedge iCLK);
      if (drop && c == 1) iReq = '0;
      if (oAck != 2'b00) begin
        got = 1'b1;
        e = sb.pop_front();
        iMemAck = 1'b0;
        chk("ack", 128'(oAck), 128'(e.ack));
        chk("err", 128'(oErr), 128'(e.err));
        chk("rdata", 128'(oRData), 128'(e.rdata));
        chk("grant", 128'(oGrant), 128'(e.ack));
        chk("latency", 128'(c), 128'(e.lat));
        chk("busy_cycles", 128'(n_busy), 128'(e.busy));
      end else if (oMemReq) begin
        n_busy++;
        chk("mem_fields", 128'({oMemWe, oMemBe, oMemAddr, oMemWData}),
            128'({sb[0].we, sb[0].be, sb[0].addr, sb[0].wdata}));
        iMemAck   = (ws >= 0) && (n_busy > ws);
        iMemRData = mrd;
      end else begin
        iMemAck = 1'b0;
      end
    end
    chk("ack_seen", 128'(got), 128'(1'b1));
  endtask

  int n_ack;

  initial begin
    iRST = 1'b1; iReq = '0; iWe = '0; iBe = '0; iAddr = '0; iWData = '0;
    iMemAck = 1'b0; iMemRData = '0;
    repeat (2) @(posedge iCLK);
    @(negedge iCLK);
    chk("rst_ctrl", 128'({oAck, oErr, oMemReq, oMemWe, oMemBe, oGrant}), 128'(0));
    chk("rst_data", {oRData, oMemAddr, oMemWData, oStallCnt}, 128'(0));
    @(posedge iCLK); #1;
    iRST = 1'b0;

    // single read, zero wait states
    set_ch(0, 1'b0, 4'hF, 32'h40, 32'h0);
    iReq = 2'b01;
    push(2'b01, 1'b0, 32'h1234, 1'b0, 32'h40, 4'hF, 32'h0, 1, 2);
    wait_ack(0, 32'h1234, 1'b0);
    @(posedge iCLK); #1;
    iReq = '0;
    @(negedge iCLK);
    chk("idle_after_done", 128'({oGrant, oMemReq, oAck}), 128'(0));
    chk("rdata_hold", 128'(oRData), 128'(32'h1234));

    // both channels held for four back-to-back transactions
    set_ch(0, 1'b0, 4'hF, 32'h100, 32'h0);
    set_ch(1, 1'b0, 4'hF, 32'h200, 32'h11111111);
    @(posedge iCLK); #1;
    iReq = 2'b11;
    for (int k = 0; k < 4; k++) begin
      if (k % 2 == 0) push(2'b10, 1'b0, 32'h1000 + k, 1'b0, 32'h200, 4'hF, 32'h11111111, 1, 2);
      else            push(2'b01, 1'b0, 32'h1000 + k, 1'b0, 32'h100, 4'hF, 32'h0, 1, 2);
    end
    for (int k = 0; k < 4; k++) begin
      wait_ack(0, 32'h1000 + k, 1'b0);
      chk("fp_grant", 128'(fp_oAck), 128'(2'b10));
    end
    @(posedge iCLK); #1;
    iReq = '0;
    @(negedge iCLK);
    chk("stall_rr", 128'(oStallCnt), 128'(32'd14));
    chk("stall_fp", 128'(fp_oStallCnt), 128'(32'd14));

    // stray memory ack while idle
    @(posedge iCLK); #1;
    iMemAck = 1'b1;
    for (int k = 0; k < 2; k++) begin
      @(negedge iCLK);
      chk("stray_memack", 128'({oAck, oMemReq}), 128'(0));
    end
    @(posedge iCLK); #1;
    iMemAck = 1'b0;

    // write with 3 wait states, request withdrawn mid-flight
    set_ch(1, 1'b1, 4'b0011, 32'h80, 32'hAABBCCDD);
    iReq = 2'b10;
    push(2'b10, 1'b0, 32'h1003, 1'b1, 32'h80, 4'b0011, 32'hAABBCCDD, 4, 5);
    wait_ack(3, 32'h55555555, 1'b1);
    @(posedge iCLK); #1;

    // write with no byte enables: no memory cycle
    set_ch(0, 1'b1, 4'b0000, 32'h300, 32'h77);
    iReq = 2'b01;
    push(2'b01, 1'b0, 32'h1003, 1'b1, 32'h300, 4'h0, 32'h77, 0, 1);
    wait_ack(0, 32'h0, 1'b0);
    @(posedge iCLK); #1;
    iReq = '0;

    // timeout on a read
    @(posedge iCLK); #1;
    set_ch(0, 1'b0, 4'hF, 32'h400, 32'h0);
    iReq = 2'b01;
    push(2'b01, 1'b1, 32'hDEADBEEF, 1'b0, 32'h400, 4'hF, 32'h0, 4, 5);
    wait_ack(-1, 32'h0, 1'b0);
    @(posedge iCLK); #1;
    iReq = '0;
    @(negedge iCLK);
    chk("idle_after_tmo", 128'({oMemReq, oGrant, oErr}), 128'(0));
    repeat (6) @(negedge iCLK);
    chk("fp_waits_forever", 128'({fp_oMemReq, fp_oAck}), 128'({1'b1, 2'b00}));

    // reset in the middle of a memory cycle
    @(posedge iCLK); #1;
    set_ch(1, 1'b0, 4'hF, 32'h500, 32'h0);
    iReq = 2'b10;
    @(negedge iCLK);
    @(negedge iCLK);
    chk("mid_busy", 128'({oMemReq, oMemAddr}), 128'({1'b1, 32'h500}));
    #2;
    iRST = 1'b1;
    #1;
    chk("async_rst_ctrl", 128'({oAck, oErr, oMemReq, oMemWe, oMemBe, oGrant, fp_oMemReq}), 128'(0));
    chk("async_rst_data", {oRData, oMemAddr, oMemWData, oStallCnt}, 128'(0));
    iReq = '0;
    @(posedge iCLK); #1;
    iRST = 1'b0;
    n_ack = 0;
    for (int k = 0; k < 6; k++) begin
      @(negedge iCLK);
      if (oAck != 2'b00) n_ack++;
    end
    chk("no_ack_after_rst", 128'(n_ack), 128'(0));

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
